char_bus_ctrl: RTL and testbench

Memory-mapped bus controller between the CPU's single write/read port and the text-mode peripherals. It decodes the address, routes CPU writes to main memory, the character RAM write port or the hex-display register, and muxes CPU read data. It also runs a hardware screen-fill sequencer that shares the character RAM write port with the CPU under fixed CPU priority.

---
 rtl/coffee_bus_pkg.sv | 18 +
 rtl/char_bus_ctrl_if.sv | 30 +++
 rtl/char_fill_engine.sv | 77 +++++++
 rtl/char_bus_ctrl.sv | 105 ++++++++++
 tb/tb_char_bus_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coffee_bus_pkg.sv
// Shared constants and types for the text-mode bus controller.
// Address map, control bit positions and fill FSM states.
package coffee_bus_pkg;

    localparam logic [3:0]  CHAR_BASE = 4'hE;
    localparam logic [15:0] CTRL_ADDR = 16'hFFFE;
    localparam logic [15:0] DISP_ADDR = 16'hFFFF;

    localparam int START = 8;
    localparam int ABORT = 9;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

endpackage

// File: rtl/char_bus_ctrl_if.sv
// CPU-side bus bundle: address/data/strobe out, read data back,
// plus the main memory read data and write enable.
interface char_bus_ctrl_if;

    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_wren;
    logic [31:0] mem_q;
    logic [31:0] cpu_rdata;
    logic        mem_wren;

    modport master (
        output cpu_addr,
        output cpu_wdata,
        output cpu_wren,
        output mem_q,
        input  cpu_rdata,
        input  mem_wren
    );

    modport slave (
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_wren,
        input  mem_q,
        output cpu_rdata,
        output mem_wren
    );

endinterface

// File: rtl/char_fill_engine.sv
// Screen-fill sequencer: walks cnt over the character RAM,
// yielding the write port whenever the CPU writes a cell.
module char_fill_engine
    import coffee_bus_pkg::*;
#(
    parameter int CHAR_AW  = 12,
    parameter int FILL_LEN = 4096
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               stall_i,
    input  logic [7:0]         char_i,
    output logic               req_o,
    output logic [CHAR_AW-1:0] req_addr_o,
    output logic [7:0]         req_data_o,
    output logic [CHAR_AW:0]   cnt_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam logic [CHAR_AW:0] LAST = (CHAR_AW+1)'(FILL_LEN - 1);

    fill_state_e      state_q, state_d;
    logic [CHAR_AW:0] cnt_q, cnt_d;
    logic [7:0]       char_q, char_d;

    // State, counter and fill character registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            char_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
        end
    end

    // Next state: abort beats start, start restarts from any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        req_o   = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else if (start_i) begin
            state_d = FILL;
            cnt_d   = '0;
            char_d  = char_i;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (!stall_i) begin
                        req_o = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    assign req_addr_o = cnt_q[CHAR_AW-1:0];
    assign req_data_o = char_q;
    assign cnt_o      = cnt_q;
    assign busy_o     = (state_q == FILL);
    assign done_o     = (state_q == DONE);

endmodule

// File: rtl/char_bus_ctrl.sv
// Address decode, write routing, character port arbitration
// (CPU over fill), hex display register and CPU read mux.
module char_bus_ctrl #(
    parameter int          CHAR_AW   = 12,
    parameter int          FILL_LEN  = 4096,
    parameter logic [3:0]  CHAR_BASE = coffee_bus_pkg::CHAR_BASE,
    parameter logic [15:0] CTRL_ADDR = coffee_bus_pkg::CTRL_ADDR,
    parameter logic [15:0] DISP_ADDR = coffee_bus_pkg::DISP_ADDR
) (
    input  logic               clock,
    input  logic               rst,
    char_bus_ctrl_if.slave     bus,
    output logic [CHAR_AW-1:0] char_addr,
    output logic [7:0]         char_data,
    output logic               char_wren,
    output logic [15:0]        hex_value,
    output logic               fill_busy,
    output logic               fill_done
);

    logic               ctrl_hit, disp_hit, char_hit;
    logic               cpu_char_wr, ctrl_wr;
    logic               start, abort;
    logic               fill_req;
    logic [CHAR_AW-1:0] fill_addr;
    logic [7:0]         fill_data;
    logic [CHAR_AW:0]   fill_cnt;
    logic [CHAR_AW-1:0] char_addr_q;
    logic [7:0]         char_data_q;
    logic               char_wren_q;
    logic [15:0]        hex_q;
    logic               unused_wdata;

    assign ctrl_hit = (bus.cpu_addr == CTRL_ADDR);
    assign disp_hit = (bus.cpu_addr == DISP_ADDR);
    assign char_hit = (bus.cpu_addr[15:12] == CHAR_BASE)
                    && !ctrl_hit && !disp_hit;

    assign cpu_char_wr = bus.cpu_wren && char_hit;
    assign ctrl_wr     = bus.cpu_wren && ctrl_hit;
    assign abort = ctrl_wr && bus.cpu_wdata[coffee_bus_pkg::ABORT];
    assign start = ctrl_wr && bus.cpu_wdata[coffee_bus_pkg::START]
                 && !bus.cpu_wdata[coffee_bus_pkg::ABORT];

    assign bus.mem_wren = bus.cpu_wren
                        && !(char_hit || ctrl_hit || disp_hit);

    assign bus.cpu_rdata = ctrl_hit
        ? {fill_busy, 15'b0, 16'(fill_cnt)}
        : bus.mem_q;

    assign unused_wdata = ^bus.cpu_wdata[31:16];

    char_fill_engine #(
        .CHAR_AW  (CHAR_AW),
        .FILL_LEN (FILL_LEN)
    ) u_fill (
        .clock      (clock),
        .rst        (rst),
        .start_i    (start),
        .abort_i    (abort),
        .stall_i    (cpu_char_wr),
        .char_i     (bus.cpu_wdata[7:0]),
        .req_o      (fill_req),
        .req_addr_o (fill_addr),
        .req_data_o (fill_data),
        .cnt_o      (fill_cnt),
        .busy_o     (fill_busy),
        .done_o     (fill_done)
    );

    // Character write port: CPU write wins, else the fill request.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            char_addr_q <= '0;
            char_data_q <= '0;
            char_wren_q <= 1'b0;
        end else if (cpu_char_wr) begin
            char_addr_q <= bus.cpu_addr[CHAR_AW-1:0];
            char_data_q <= bus.cpu_wdata[7:0];
            char_wren_q <= 1'b1;
        end else if (fill_req) begin
            char_addr_q <= fill_addr;
            char_data_q <= fill_data;
            char_wren_q <= 1'b1;
        end else begin
            char_wren_q <= 1'b0;
        end
    end

    // Hex display register, loaded by a write to the display address.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hex_q <= '0;
        end else if (bus.cpu_wren && disp_hit) begin
            hex_q <= bus.cpu_wdata[15:0];
        end
    end

    assign char_addr = char_addr_q;
    assign char_data = char_data_q;
    assign char_wren = char_wren_q;
    assign hex_value = hex_q;

endmodule

// File: tb/tb_char_bus_ctrl.sv
// Directed bench for char_bus_ctrl with a 16-cell fill.
// Each task drives one scenario and checks its own results.
module tb_char_bus_ctrl;

    localparam int AW = 12;
    localparam int FL = 16;

    logic          clock;
    logic          rst;
    logic [AW-1:0] char_addr;
    logic [7:0]    char_data;
    logic          char_wren;
    logic [15:0]   hex_value;
    logic          fill_busy;
    logic          fill_done;

    int tests;
    int fails;

    char_bus_ctrl_if bus ();

    char_bus_ctrl #(
        .CHAR_AW  (AW),
        .FILL_LEN (FL)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .bus       (bus),
        .char_addr (char_addr),
        .char_data (char_data),
        .char_wren (char_wren),
        .hex_value (hex_value),
        .fill_busy (fill_busy),
        .fill_done (fill_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [31:0] d,
                         input logic w);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_wren  = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(16'h0000, 32'h0, 1'b0);
        bus.mem_q = 32'h0;
        #1;
        tests++;
        if ({char_wren, char_addr, char_data, hex_value,
             fill_busy, fill_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %b%h%h%h%b%b want 0",
                     char_wren, char_addr, char_data, hex_value,
                     fill_busy, fill_done);
        end
        @(negedge clock);
        rst = 1'b0;
        step();
        tests++;
        if (char_wren !== 1'b0 || fill_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle wren=%b busy=%b want 0 0",
                     char_wren, fill_busy);
        end
    endtask

    task automatic test_decode();
        drive(16'hFFFF, 32'h1234ABCD, 1'b1);
        #1;
        tests++;
        if (bus.mem_wren !== 1'b0) begin
            fails++;
            $display("FAIL disp_memwren got %b want 0", bus.mem_wren);
        end
        step();
        tests++;
        if (hex_value !== 16'hABCD) begin
            fails++;
            $display("FAIL disp_hex got %h want abcd", hex_value);
        end
        bus.mem_q = 32'hDEADBEEF;
        drive(16'h0100, 32'h55, 1'b1);
        #1;
        tests++;
        if (bus.mem_wren !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL mem_decode wren=%b rdata=%h want 1 deadbeef",
                     bus.mem_wren, bus.cpu_rdata);
        end
        drive(16'hE123, 32'h55, 1'b1);
        #1;
        tests++;
        if (bus.mem_wren !== 1'b0) begin
            fails++;
            $display("FAIL char_memwren got %b want 0", bus.mem_wren);
        end
        step();
        drive(16'h0000, 32'h0, 1'b0);
        tests++;
        if ({char_wren, char_addr, char_data} !== {1'b1, 12'h123, 8'h55}) begin
            fails++;
            $display("FAIL char_write got %b %h %h want 1 123 55",
                     char_wren, char_addr, char_data);
        end
        step();
        tests++;
        if (char_wren !== 1'b0) begin
            fails++;
            $display("FAIL char_wren_drop got %b want 0", char_wren);
        end
    endtask

    task automatic test_fill();
        int bad;
        bad = 0;
        drive(16'hFFFE, 32'h141, 1'b1);
        step();
        drive(16'hFFFE, 32'h0, 1'b0);
        #1;
        tests++;
        if (fill_busy !== 1'b1 || char_wren !== 1'b0
            || bus.cpu_rdata !== 32'h80000000) begin
            fails++;
            $display("FAIL fill_start busy=%b wren=%b rdata=%h want 1 0 80000000",
                     fill_busy, char_wren, bus.cpu_rdata);
        end
        drive(16'h0000, 32'h0, 1'b0);
        for (int k = 0; k < FL; k++) begin
            step();
            if ({char_wren, char_addr, char_data} !== {1'b1, 12'(k), 8'h41}) begin
                bad++;
                $display("FAIL fill_write%0d got %b %h %h want 1 %h 41", k,
                         char_wren, char_addr, char_data, k);
            end
            if (k < FL - 1 && fill_done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL fill_sequence got %0d bad cycles want 0", bad);
        end
        tests++;
        if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
            fails++;
            $display("FAIL fill_done got done=%b busy=%b want 1 0",
                     fill_done, fill_busy);
        end
        step();
        tests++;
        if (fill_done !== 1'b0 || char_wren !== 1'b0) begin
            fails++;
            $display("FAIL fill_after got done=%b wren=%b want 0 0",
                     fill_done, char_wren);
        end
    endtask

    task automatic test_contention();
        int bad;
        int fe;
        int nfill;
        logic [20:0] exp;
        bad = 0;
        fe = 0;
        nfill = 0;
        drive(16'hFFFE, 32'h142, 1'b1);
        step();
        for (int c = 1; c <= FL + 2; c++) begin
            if (c == 4 || c == 9) drive(16'hE005, 32'h7A, 1'b1);
            else drive(16'h0000, 32'h0, 1'b0);
            step();
            if (c == 4 || c == 9) begin
                exp = {1'b1, 12'h005, 8'h7A};
            end else begin
                exp = {1'b1, 12'(fe), 8'h42};
                fe++;
            end
            if ({char_wren, char_addr, char_data} !== exp) begin
                bad++;
                $display("FAIL cont_cycle%0d got %b %h %h want %h", c,
                         char_wren, char_addr, char_data, exp);
            end
            if (char_wren === 1'b1 && char_data === 8'h42) nfill++;
            if (fill_done !== (c == FL + 2)) begin
                bad++;
                $display("FAIL cont_done%0d got %b", c, fill_done);
            end
        end
        drive(16'h0000, 32'h0, 1'b0);
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL contention got %0d bad cycles want 0", bad);
        end
        tests++;
        if (nfill != FL) begin
            fails++;
            $display("FAIL cont_fill_count got %0d want %0d", nfill, FL);
        end
        step();
    endtask

    task automatic test_abort();
        drive(16'hFFFE, 32'h143, 1'b1);
        step();
        drive(16'h0000, 32'h0, 1'b0);
        repeat (5) step();
        drive(16'hFFFE, 32'h200, 1'b1);
        step();
        drive(16'hFFFE, 32'h0, 1'b0);
        #1;
        tests++;
        if ({fill_busy, fill_done, char_wren} !== 3'b000) begin
            fails++;
            $display("FAIL abort_state got busy=%b done=%b wren=%b want 0 0 0",
                     fill_busy, fill_done, char_wren);
        end
        tests++;
        if (bus.cpu_rdata !== 32'h00000005) begin
            fails++;
            $display("FAIL abort_cnt got %h want 00000005", bus.cpu_rdata);
        end
        step();
        tests++;
        if (fill_done !== 1'b0 || char_wren !== 1'b0) begin
            fails++;
            $display("FAIL abort_quiet got done=%b wren=%b want 0 0",
                     fill_done, char_wren);
        end
        drive(16'h0000, 32'h0, 1'b0);
    endtask

    task automatic test_restart();
        drive(16'hFFFE, 32'h143, 1'b1);
        step();
        drive(16'h0000, 32'h0, 1'b0);
        repeat (3) step();
        drive(16'hFFFE, 32'h130, 1'b1);
        step();
        drive(16'h0000, 32'h0, 1'b0);
        tests++;
        if (fill_busy !== 1'b1) begin
            fails++;
            $display("FAIL restart_busy got %b want 1", fill_busy);
        end
        step();
        tests++;
        if ({char_wren, char_addr, char_data} !== {1'b1, 12'h000, 8'h30}) begin
            fails++;
            $display("FAIL restart_first got %b %h %h want 1 000 30",
                     char_wren, char_addr, char_data);
        end
        step();
        tests++;
        if ({char_wren, char_addr, char_data} !== {1'b1, 12'h001, 8'h30}) begin
            fails++;
            $display("FAIL restart_second got %b %h %h want 1 001 30",
                     char_wren, char_addr, char_data);
        end
        drive(16'hFFFE, 32'h300, 1'b1);
        step();
        drive(16'h0000, 32'h0, 1'b0);
        tests++;
        if (fill_busy !== 1'b0 || char_wren !== 1'b0) begin
            fails++;
            $display("FAIL abort_wins got busy=%b wren=%b want 0 0",
                     fill_busy, char_wren);
        end
        step();
    endtask

    task automatic test_reset_midfill();
        int bad;
        bad = 0;
        drive(16'hFFFE, 32'h144, 1'b1);
        step();
        drive(16'h0000, 32'h0, 1'b0);
        repeat (8) step();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({char_wren, char_addr, char_data, hex_value,
             fill_busy, fill_done} !== '0) begin
            fails++;
            $display("FAIL midfill_reset got %b %h %h %h %b %b want 0",
                     char_wren, char_addr, char_data, hex_value,
                     fill_busy, fill_done);
        end
        #3;
        rst = 1'b0;
        repeat (20) begin
            step();
            if (char_wren !== 1'b0 || fill_busy !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL midfill_after got %0d active cycles want 0", bad);
        end
        drive(16'hFFFE, 32'h0, 1'b0);
        #1;
        tests++;
        if (bus.cpu_rdata !== 32'h0) begin
            fails++;
            $display("FAIL midfill_cnt got %h want 00000000", bus.cpu_rdata);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_decode();
        test_fill();
        test_contention();
        test_abort();
        test_restart();
        test_reset_midfill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
